sha256_req_arbiter: RTL and testbench
=====================================

Name: sha256_req_arbiter

Overview:
- Shares one SHA-256 hashing core (single-block, start/hashed interface) among NUM_REQ requesters.
- Round-robin arbitration picks one pending request and captures its message. It pulses the core start, waits for core completion, then returns the digest tagged with the requester ID over a valid/ready response channel.
- Sits between the requester fabric and the hash core; it is the core's only driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MSG_SIZE, 120, message width in bits fed to the core
- HASH_W, 256, digest width
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant/accept; high only in IDLE for the chosen requester
- req_msg  in  NUM_REQ*MSG_SIZE  packed messages; requester i occupies bits [i*MSG_SIZE +: MSG_SIZE]
- core_start  out  1  single-cycle start pulse to the core
- core_message  out  MSG_SIZE  captured message; held stable from the start pulse until the response is accepted
- core_hashed  in  HASH_W  core digest
- core_done  in  1  core completion, level or pulse; sampled only in BUSY
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  $clog2(NUM_REQ)  index of the served requester
- rsp_hash  out  HASH_W  registered digest
- rsp_error  out  1  watchdog timeout flag; constant 0 when the feature is compiled out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0, req_ready=0, core_start=0, core_message=0, rsp_valid=0, rsp_id=0, rsp_hash=0, rsp_error=0, busy=0.
- States: IDLE, LAUNCH, BUSY, RESP.
- IDLE:
  - req_ready is combinational and one-hot. It selects the first asserted req_valid searching from rr_ptr upward, with wrap-around.
  - On handshake (req_valid[i] & req_ready[i]) at the clock edge: capture req_msg slice i into core_message and i into rsp_id; go to LAUNCH.
  - No valid requests: stay in IDLE with req_ready=0.
- LAUNCH: core_start=1 for exactly one cycle; go to BUSY.
- BUSY:
  - core_done is ignored in the LAUNCH cycle and the first BUSY cycle, so a stale done from the previous job is not accepted.
  - On core_done from the second BUSY cycle onward: register core_hashed into rsp_hash, set rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_hash stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid=0, rr_ptr=(rsp_id+1) mod NUM_REQ, return to IDLE.
- Latency: grant edge to core_start = 1 cycle. core_done to rsp_valid = 1 cycle. Earliest next grant is the cycle after the response handshake.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 jobs.
- Boundary conditions:
  - All requesters valid: served strictly in order rr_ptr, rr_ptr+1, ... with wrap from NUM_REQ-1 to 0.
  - req_valid deasserted while not granted: no effect. Requesters must hold valid until granted.
  - rsp_ready held high: RESP lasts exactly one cycle.
  - Async reset mid-job: returns to the reset state immediately; any in-flight job is discarded. The core must be reset together with this block.

Optional Feature:
- Macro: SHA_ARB_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC without core_done: go to RESP with rsp_error=1 and rsp_hash=0.
  - rsp_error clears on the response handshake.
- Without the macro: no counter; rsp_error is tied to 0; BUSY waits indefinitely.

Decomposition:
- Package sha256_arb_pkg: arb_state_t enum (IDLE, LAUNCH, BUSY, RESP), HASH_W localparam, and a function computing the round-robin next-grant index.
- Sub-module rr_arbiter (NUM_REQ parameter; inputs req and ptr; output one-hot grant) is natural and is reused by other shared-resource blocks.

Test Plan:
- Single request: req_valid=4'b0010 with message 120'h48656c6c6f2c205348412d32353621 and a core model returning 256'hd0e8b8f1...a46271 after 70 cycles. Required: core_start pulses once, core_message matches the message, rsp_id=1, rsp_hash equals the digest, rsp_valid 1 cycle after core_done.
- All four requesters valid from reset: grants occur in order 0,1,2,3, then 0 again. Each rsp_id matches its own message's digest.
- Backpressure: rsp_ready=0 for 20 cycles in RESP. Required: rsp_valid, rsp_id and rsp_hash stay stable, req_ready stays 0, no second core_start.
- Stale done: core_done held high while entering LAUNCH. Required: the response is not produced before the second BUSY cycle.
- Reset mid-job: reset driven low while in BUSY. Required: all outputs return to reset values asynchronously; after release, rr_ptr=0 and requester 0 wins first.
- With SHA_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, the core never asserts done. Required: rsp_valid with rsp_error=1 and rsp_hash=0 at BUSY cycle 16; rsp_error clears after the handshake.

Source files
------------

// File: rtl/sha256_arb_pkg.sv
// sha256_arb_pkg: state encoding, digest width and the round-robin pick helper
// shared by the SHA-256 request arbiter and its rr_arbiter sub-block.
package sha256_arb_pkg;

   localparam int HASH_W = 256;
   localparam int RR_MAX = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   // First set bit of req at or after ptr, wrapping at n; returns n when req is empty.
   function automatic int rr_next_idx(input logic [RR_MAX-1:0] req, input int ptr, input int n);
      int                idx;
      int                j;
      logic [RR_MAX-1:0] sh;
      idx = n;
      for (int k = RR_MAX - 1; k >= 0; k--) begin
         if (k < n) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            sh = req >> j;
            if (sh[0]) idx = j;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sha256_req_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant starting the search at ptr.
module rr_arbiter
   import sha256_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant
);

   int win;

   always_comb begin
      win   = rr_next_idx(RR_MAX'(req), int'(ptr), NUM_REQ);
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = (win == i);
      end
   end

endmodule

// File: rtl/sha256_req_arbiter.sv
// sha256_req_arbiter: shares one SHA-256 core among NUM_REQ requesters with round-robin grant.
// Define SHA_ARB_TIMEOUT_EN to add a BUSY watchdog that reports rsp_error on expiry.
module sha256_req_arbiter #(
   parameter int  NUM_REQ     = 4,
   parameter int  MSG_SIZE    = 120,
   parameter int  HASH_W      = sha256_arb_pkg::HASH_W,
   parameter int  TIMEOUT_CYC = 1024,
   localparam int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*MSG_SIZE-1:0] req_msg,
   output logic                        core_start,
   output logic [MSG_SIZE-1:0]         core_message,
   input  logic [HASH_W-1:0]           core_hashed,
   input  logic                        core_done,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [ID_W-1:0]             rsp_id,
   output logic [HASH_W-1:0]           rsp_hash,
   output logic                        rsp_error,
   output logic                        busy
);

   import sha256_arb_pkg::*;

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                core_start_q, core_start_d;
   logic [MSG_SIZE-1:0] core_message_q, core_message_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [HASH_W-1:0]   rsp_hash_q, rsp_hash_d;
   logic                done_arm_q, done_arm_d;

   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_id;
   logic [MSG_SIZE-1:0] grant_msg;
   logic                handshake;

`ifdef SHA_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
   logic                rsp_error_q, rsp_error_d;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   always_comb begin
      grant_id  = '0;
      grant_msg = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_id  = ID_W'(i);
            grant_msg = req_msg[i*MSG_SIZE +: MSG_SIZE];
         end
      end
   end

   // Gated by reset so no grant is offered while the block is held in reset.
   assign req_ready = (state_q == IDLE && reset) ? grant : '0;
   assign handshake = |(req_valid & req_ready);

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      core_start_d   = 1'b0;
      core_message_d = core_message_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_id_d       = rsp_id_q;
      rsp_hash_d     = rsp_hash_q;
      done_arm_d     = done_arm_q;
`ifdef SHA_ARB_TIMEOUT_EN
      wd_cnt_d       = wd_cnt_q;
      rsp_error_d    = rsp_error_q;
`endif
      case (state_q)
         IDLE: begin
            if (handshake) begin
               state_d        = LAUNCH;
               core_start_d   = 1'b1;
               core_message_d = grant_msg;
               rsp_id_d       = grant_id;
            end
         end
         LAUNCH: begin
            state_d    = BUSY;
            done_arm_d = 1'b0;
`ifdef SHA_ARB_TIMEOUT_EN
            wd_cnt_d   = '0;
`endif
         end
         BUSY: begin
            // done_arm_q is low in the first BUSY cycle so a leftover done level is ignored.
            done_arm_d = 1'b1;
`ifdef SHA_ARB_TIMEOUT_EN
            wd_cnt_d   = wd_cnt_q + 1'b1;
`endif
            if (done_arm_q && core_done) begin
               rsp_hash_d  = core_hashed;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
`ifdef SHA_ARB_TIMEOUT_EN
            else if (wd_cnt_d == CNT_W'(TIMEOUT_CYC)) begin
               rsp_hash_d  = '0;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               state_d     = RESP;
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rr_ptr_d    = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
               state_d     = IDLE;
`ifdef SHA_ARB_TIMEOUT_EN
               rsp_error_d = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         rr_ptr_q       <= '0;
         core_start_q   <= 1'b0;
         core_message_q <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_id_q       <= '0;
         rsp_hash_q     <= '0;
         done_arm_q     <= 1'b0;
`ifdef SHA_ARB_TIMEOUT_EN
         wd_cnt_q       <= '0;
         rsp_error_q    <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         core_start_q   <= core_start_d;
         core_message_q <= core_message_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_id_q       <= rsp_id_d;
         rsp_hash_q     <= rsp_hash_d;
         done_arm_q     <= done_arm_d;
`ifdef SHA_ARB_TIMEOUT_EN
         wd_cnt_q       <= wd_cnt_d;
         rsp_error_q    <= rsp_error_d;
`endif
      end
   end

   assign core_start   = core_start_q;
   assign core_message = core_message_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_hash     = rsp_hash_q;
   assign busy         = (state_q != IDLE);
`ifdef SHA_ARB_TIMEOUT_EN
   assign rsp_error    = rsp_error_q;
`else
   assign rsp_error    = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_req_arbiter.sv
// tb_sha256_req_arbiter: scoreboard bench with a behavioural core model and request/response model.
module tb_sha256_req_arbiter;

   localparam int N   = 4;
   localparam int MW  = 120;
   localparam int HW  = 256;
   localparam int IDW = 2;
`ifdef SHA_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif
   localparam int LONG_LAT = (TO > 100) ? 70 : 12;

   typedef struct {
      int            id;
      logic [HW-1:0] hash;
      logic          err;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*MW-1:0] req_msg;
   logic            core_start, core_done;
   logic [MW-1:0]   core_message;
   logic [HW-1:0]   core_hashed;
   logic            rsp_valid, rsp_ready, rsp_error, busy;
   logic [IDW-1:0]  rsp_id;
   logic [HW-1:0]   rsp_hash;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int  mptr, cur_id, jobs_left, lat_min, lat_max, exp_rise_cyc, n_start;
   bit  inflight, auto_rereq, rnd_mode, stale_mode, no_done, in_reset;
   logic [MW-1:0] msgs [N];
   exp_t          sb_q[$];
   logic [MW-1:0] msg_q[$];
   int            grant_log[$];

   sha256_req_arbiter #(
      .NUM_REQ(N), .MSG_SIZE(MW), .HASH_W(HW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_msg(req_msg), .core_start(core_start), .core_message(core_message),
      .core_hashed(core_hashed), .core_done(core_done), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_hash(rsp_hash),
      .rsp_error(rsp_error), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [HW-1:0] ref_digest(input logic [MW-1:0] m);
      return {m, ~m, 16'h5a3c};
   endfunction

   function automatic logic [MW-1:0] rand_msg();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[MW-1:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_h(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic raise(input int i, input logic [MW-1:0] m);
      msgs[i] = m;
      req_msg[i*MW +: MW] = m;
      req_valid[i] = 1'b1;
   endtask

   task automatic flush_model();
      sb_q.delete();
      msg_q.delete();
      inflight = 0;
      mptr     = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
      chk({tag, "_core_start"}, 64'(core_start), 64'(0));
      chk_h({tag, "_core_message"}, HW'(core_message), '0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
      chk_h({tag, "_rsp_hash"}, rsp_hash, '0);
      chk({tag, "_rsp_error"}, 64'(rsp_error), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   // One clock of the requester side: predict the grant, then update stimulus.
   task automatic step();
      logic [N-1:0] exp_rdy;
      int           pick;
      bit           rel;
      exp_t         e;
      pick    = -1;
      rel     = 0;
      exp_rdy = '0;
      @(negedge clk);
      if (!inflight) begin
         for (int k = N - 1; k >= 0; k--)
            if (req_valid[(mptr + k) % N]) pick = (mptr + k) % N;
         if (pick >= 0) exp_rdy[pick] = 1'b1;
      end else if (rsp_valid && rsp_ready) begin
         rel = 1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (pick >= 0) begin
         e.id   = pick;
         e.err  = no_done;
         e.hash = no_done ? '0 : ref_digest(msgs[pick]);
         sb_q.push_back(e);
         msg_q.push_back(msgs[pick]);
         grant_log.push_back(pick);
         inflight = 1;
         cur_id   = pick;
      end
      @(posedge clk); #1;
      if (rel) begin
         inflight = 0;
         mptr     = (cur_id + 1) % N;
      end
      if (pick >= 0) begin
         req_valid[pick] = 1'b0;
         if (auto_rereq && jobs_left > 0) begin
            raise(pick, rand_msg());
            jobs_left--;
         end
      end
      if (rnd_mode) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && jobs_left > 0 && $urandom_range(0, 99) < 25) begin
               raise(i, rand_msg());
               jobs_left--;
            end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k;
      k = 0;
      while (!(!inflight && sb_q.size() == 0 && req_valid == '0 && jobs_left == 0 && !rsp_valid)
             && k < budget) begin
         step();
         k++;
      end
      if (k >= budget) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, budget);
      end
   endtask

   // Behavioural hash core: digest after a random latency, or a held done level in stale mode.
   initial begin
      bit            pend;
      bit            prev_start;
      int            cnt;
      logic [MW-1:0] cmsg;
      pend = 0; prev_start = 0; cnt = 0; cmsg = '0;
      core_done = 1'b0;
      core_hashed = '0;
      forever begin
         @(posedge clk); #1;
         core_done = stale_mode;
         if (in_reset) begin
            pend = 0;
            prev_start = 0;
         end else begin
            if (core_start) begin
               n_start++;
               chk("core_start_pulse", 64'(prev_start), 64'(0));
               if (msg_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL core_message: start seen with no granted job (cycle %0d)", cyc);
               end else begin
                  chk_h("core_message", HW'(core_message), HW'(msg_q.pop_front()));
               end
               cmsg = core_message;
               cnt  = $urandom_range(lat_min, lat_max);
               pend = !stale_mode && !no_done;
               if (stale_mode) begin
                  core_hashed  = ref_digest(cmsg);
                  exp_rise_cyc = cyc + 3;
               end
               if (no_done) exp_rise_cyc = cyc + 1 + TO;
            end else if (pend) begin
               cnt--;
               if (cnt <= 0) begin
                  core_done    = 1'b1;
                  core_hashed  = ref_digest(cmsg);
                  exp_rise_cyc = cyc + 1;
                  pend         = 0;
               end
            end
            prev_start = core_start;
         end
      end
   end

   // Response monitor: pops the scoreboard on each accepted response.
   initial begin
      bit            prev_v, prev_r;
      logic [IDW-1:0] prev_id;
      logic [HW-1:0] prev_h;
      exp_t          e;
      prev_v = 0; prev_r = 0; prev_id = '0; prev_h = '0;
      forever begin
         @(negedge clk);
         if (in_reset) begin
            prev_v = 0;
         end else begin
            if (prev_v && !prev_r) begin
               chk("rsp_valid_hold", 64'(rsp_valid), 64'(1));
               chk("rsp_id_hold", 64'(rsp_id), 64'(prev_id));
               chk_h("rsp_hash_hold", rsp_hash, prev_h);
            end
            if (rsp_valid && !prev_v) chk("rsp_latency", 64'(cyc), 64'(exp_rise_cyc));
            if (rsp_valid && rsp_ready) begin
               if (sb_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL rsp_unexpected: id %0d with no job outstanding", rsp_id);
               end else begin
                  e = sb_q.pop_front();
                  chk("rsp_id", 64'(rsp_id), 64'(e.id));
                  chk_h("rsp_hash", rsp_hash, e.hash);
                  chk("rsp_error", 64'(rsp_error), 64'(e.err));
               end
            end
            prev_v  = rsp_valid;
            prev_r  = rsp_ready;
            prev_id = rsp_id;
            prev_h  = rsp_hash;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "global timeout");
   end

   initial begin
      int k;
      int n0;
      reset = 1'b0; in_reset = 1; req_valid = '0; req_msg = '0; rsp_ready = 1'b1;
      auto_rereq = 0; rnd_mode = 0; stale_mode = 0; no_done = 0;
      jobs_left = 0; lat_min = 2; lat_max = 8; n_start = 0; exp_rise_cyc = 0;
      for (int i = 0; i < N; i++) msgs[i] = '0;
      flush_model();
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("por");
      reset = 1'b1; in_reset = 0;

      // single request from requester 1
      lat_min = LONG_LAT; lat_max = LONG_LAT;
      n0 = n_start;
      raise(1, 120'h48656c6c6f2c205348412d32353621);
      wait_idle(400, "single");
      chk("single_start_count", 64'(n_start - n0), 64'(1));

      // all four valid from reset: order 0,1,2,3,0
      reset = 1'b0; in_reset = 1;
      flush_model();
      for (int i = 0; i < N; i++) raise(i, rand_msg());
      #1 check_reset_outputs("reset_all_valid");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1; in_reset = 0;
      grant_log.delete();
      lat_min = 2; lat_max = 8; auto_rereq = 1; jobs_left = 1;
      wait_idle(600, "all_valid");
      auto_rereq = 0;
      chk("rr_order_len", 64'(grant_log.size()), 64'(5));
      for (int i = 0; i < 5 && i < grant_log.size(); i++)
         chk("rr_order", 64'(grant_log[i]), 64'(i % N));

      // backpressure: 20 cycles with rsp_ready low while others request
      rsp_ready = 1'b0;
      raise(2, rand_msg());
      k = 0;
      while (!rsp_valid && k < 100) begin step(); k++; end
      chk("bp_rsp_seen", 64'(rsp_valid), 64'(1));
      raise(0, rand_msg());
      raise(3, rand_msg());
      n0 = n_start;
      repeat (20) step();
      chk("bp_no_restart", 64'(n_start - n0), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
      rsp_ready = 1'b1;
      wait_idle(400, "backpressure");

      // stale done held high across launch
      stale_mode = 1;
      raise(1, rand_msg());
      wait_idle(100, "stale");
      stale_mode = 0;

`ifdef SHA_ARB_TIMEOUT_EN
      no_done = 1;
      raise(3, rand_msg());
      wait_idle(200, "timeout");
      no_done = 0;
      chk("timeout_err_cleared", 64'(rsp_error), 64'(0));
`endif

      // randomized traffic with random backpressure
      rnd_mode = 1; lat_min = 2; lat_max = 12; jobs_left = 30;
      wait_idle(3000, "random");
      rnd_mode = 0; rsp_ready = 1'b1;

      // asynchronous reset in the middle of a job
      lat_min = LONG_LAT; lat_max = LONG_LAT;
      raise(2, rand_msg());
      k = 0;
      while (!busy && k < 20) begin step(); k++; end
      repeat (5) step();
      chk("midjob_busy", 64'(busy), 64'(1));
      #2 reset = 1'b0; in_reset = 1;
      #1 check_reset_outputs("async_mid_job");
      flush_model();
      for (int i = 0; i < N; i++) raise(i, rand_msg());
      repeat (3) @(posedge clk);
      #1 reset = 1'b1; in_reset = 0;
      grant_log.delete();
      lat_min = 2; lat_max = 8;
      wait_idle(800, "after_reset");
      chk("after_reset_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
